// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes and FSM state encoding for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_extract.sv
// rtl/lsu_extract.sv - little-endian lane select with sign/zero extension
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword and widen it according to funct3
  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    data   = word;
    case (size)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'h000000, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'h0000, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM in front of the dm word port
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] dm_a_o,
  output logic [31:0] dm_wd_o,
  output logic        dm_we_o,
  input  logic [31:0] dm_rd_i
);

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [15:0] wd_lo_q;   // only the low halfword is needed after acceptance
  logic [31:0] merge_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        req_bad;

  lsu_extract u_extract (
    .word   (dm_rd_i),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .data   (load_data)
  );

  // Classify the incoming request as invalid or misaligned
  always_comb begin
    req_bad = 1'b0;
    case (size_i)
      F3_LB:   req_bad = 1'b0;
      F3_LH:   req_bad = addr_i[0];
      F3_LW:   req_bad = |addr_i[1:0];
      F3_LBU:  req_bad = we_i;
      F3_LHU:  req_bad = we_i | addr_i[0];
      default: req_bad = 1'b1;
    endcase
  end

  // Overlay the store byte/halfword onto the word fetched from dm
  always_comb begin
    merged = dm_rd_i;
    if (size_q == F3_LB) merged[{addr_q[1:0], 3'b000} +: 8] = wd_lo_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wd_lo_q;
  end

  assign dm_a_o  = {addr_q[31:2], 2'b00};
  assign dm_wd_o = merge_q;
  assign dm_we_o = (state == ST_WRITE);
  assign stall_o = req_i && (state != ST_DONE);

  // Request sequencing: accept, load / read-modify-write / write, then one DONE cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wd_lo_q <= '0;
      merge_q <= '0;
      rd_o    <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            size_q  <= size_i;
            wd_lo_q <= wd_i[15:0];
            if (req_bad) begin
              err_o <= 1'b1;
              rd_o  <= '0;
              state <= ST_DONE;
            end else if (!we_i) begin
              state <= ST_LOAD;
            end else if (size_i == F3_LW) begin
              merge_q <= wd_i;
              state   <= ST_WRITE;
            end else begin
              state <= ST_RMW_READ;
            end
          end
        end
        ST_LOAD: begin
          rd_o  <= load_data;
          state <= ST_DONE;
        end
        ST_RMW_READ: begin
          merge_q <= merged;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          err_o <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit placed directly upstream of the `dm` data memory. It accepts one memory request at a time from the core and supports byte, halfword and word loads and stores. Sub-word stores are performed as read-modify-write over the `dm` word port. The core is stalled until each request completes. Loaded data is sign- or zero-extended and returned on a registered output.

## Interface
- No parameters; data and address width 32, fixed.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  1  memory request from core; held, with all request fields, stable while `stall_o`=1.
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all others invalid.
- `addr_i`  in  32  byte address.
- `wd_i`  in  32  store data; the low byte or halfword is used for sub-word stores.
- `rd_o`  out  32  registered load result.
- `stall_o`  out  1  core must hold its state while this is high.
- `err_o`  out  1  registered; misaligned or invalid request, valid in DONE.
- `dm_a_o`  out  32  word address to `dm`, always `{addr[31:2],2'b00}`.
- `dm_wd_o`  out  32  write data to `dm`.
- `dm_we_o`  out  1  write enable to `dm`; the write occurs on the next rising edge.
- `dm_rd_i`  in  32  combinational read data from `dm`, addressed by `dm_a_o`.

## Operation
- **FSM states:** IDLE, LOAD, RMW_READ, WRITE, DONE.
- **IDLE:** on `req_i`=1, latch `addr_i`, `size_i`, `we_i` and `wd_i`, then branch:
  - error → DONE;
  - load → LOAD;
  - SW → WRITE, with merge buffer = `wd_i`;
  - SB/SH → RMW_READ.
- **Error condition:** invalid `size_i`; halfword with `addr[0]`=1; word with `addr[1:0]`≠0; store with funct3 100/101.
- **LOAD:** extract the lane from `dm_rd_i` and register it into `rd_o`, then → DONE.
  - Lanes are little-endian: byte `addr[1:0]`=0 is bits 7:0; halfword `addr[1]`=0 is bits 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **RMW_READ:** merge buffer = `dm_rd_i` with the addressed lane replaced by `wd[7:0]` or `wd[15:0]`, then → WRITE.
- **WRITE:** `dm_we_o`=1 and `dm_wd_o` = merge buffer, then → DONE.
- **DONE:** unconditionally → IDLE. A new `req_i` is sampled only in IDLE.
- **`stall_o`:** combinational, `req_i && state!=DONE`. It is therefore high in the IDLE cycle that accepts a request and low only in DONE.
- **`err_o`:** set on entry to DONE through the error path, cleared on leaving DONE.
- **On error:** `rd_o` = 0 and no `dm` write occurs.
- **`rd_o` hold behaviour:** holds its value after a load until the next load or error. Stores do not modify it.
- **Output decode:** `dm_we_o` is decoded from state only; it is never asserted outside WRITE.

## Timing
- **Stall cycles, counted from the request cycle:**
  - error: 1;
  - LW/LB/LH/LBU/LHU: 2, with `rd_o` valid in the DONE cycle;
  - SW: 2;
  - SB/SH: 3.
- **Store commit:** the `dm` write commits on the edge that leaves WRITE.
- **Reset values:** state IDLE; `rd_o`=0, `err_o`=0, merge buffer 0, latched address 0. Hence `dm_a_o`=0, `dm_we_o`=0, `dm_wd_o`=0, and `stall_o` = `req_i`.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and `dm_we_o` drops immediately.
  - A write is never partially committed.
  - An RMW interrupted between RMW_READ and WRITE leaves memory unchanged.
- **`req_i` deasserted while stalled:** this violates protocol. The FSM still completes the latched operation.
- **Address wrap-around:** none. Upper address bits are passed through; `dm` decodes the bits it needs.

## Structure
- **`lsu_pkg`:** funct3 localparams (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`) and the state enum encoding.
- **`lsu_extract`:** one combinational sub-module for lane select and sign/zero extension, taking `dm_rd_i`, `addr[1:0]` and `size`.
- **Top level (`lsu`):** holds the FSM, the request latch, the merge buffer and the `rd_o`/`err_o` registers.
- **Test setup:** the bench instantiates `lsu` connected to the real `dm`.

## Test plan
- **SW then LW:** SW `wd`=333, `addr`=0x71000010, then LW from the same address → `stall_o` high 2 cycles each, `dm_we_o` 1 cycle, `rd_o`=333; LW from 0x71000014 → 0 after reset.
- **SB lane merge:** SW 0x11223344 @0x20, then SB `wd`=0xAB @0x21 → `stall_o` 3 cycles; LW @0x20 → 0x1122AB44.
- **Sign/zero extension:** with word @0x20 = 0x1122AB44, LB @0x21 → 0xFFFFFFAB; LBU @0x21 → 0x000000AB; LH @0x22 → 0x00001122; SH 0x8001 @0x22 then LH @0x22 → 0xFFFF8001.
- **Misalignment:**
  - LW @0x22 → `err_o`=1, `rd_o`=0, 1 stall cycle;
  - SH @0x23 → `err_o`=1, no `dm_we_o` pulse, word unchanged;
  - `size_i`=011 → `err_o`=1.
- **Reset during RMW:** assert `rst_ni`=0 while in RMW_READ of SB 0xFF @0x20 → `dm_we_o` stays 0, state IDLE, a subsequent LW @0x20 returns the pre-SB value.
- **Back-to-back requests:** LW immediately followed by SW with `req_i` held → the second request is accepted in the IDLE cycle after DONE, with no lost or duplicated write.
